// File: rtl/tt_snapshot_shift_ctrl.sv
// tt_snapshot_shift_ctrl: prescaled snapshot counter that serialises one counter snapshot per request
module tt_snapshot_shift_ctrl #(
  parameter int CNT_W      = 4,
  parameter int DIV_W      = 3,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             start,
  input  logic             auto_mode,
  input  logic             clr_ovr,
  output logic             sout,
  output logic             frame,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, GAP = 2'd3;
  localparam int IW = $clog2(CNT_W > GAP_CYCLES ? CNT_W : GAP_CYCLES);
  logic [1:0]       state;
  logic [DIV_W-1:0] pre;
  logic [CNT_W-1:0] shreg;
  logic [IW-1:0]    idx;
  logic             tick, req;
  assign tick  = en && pre == div;
  assign req   = start | (auto_mode & tick);
  assign busy  = state != IDLE;
  assign frame = state == SHIFT;
  assign sout  = frame & shreg[CNT_W-1];
  assign done  = state == GAP && idx == '0;
  // idx is shared: bit index while shifting, remaining gap cycles afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pre     <= '0;
      cnt     <= '0;
      shreg   <= '0;
      idx     <= '0;
      overrun <= 1'b0;
    end else begin
      pre     <= tick ? '0 : en ? pre + 1'b1 : pre;
      cnt     <= cnt + CNT_W'(tick);
      overrun <= (req & busy) | (overrun & ~clr_ovr);
      case (state)
        IDLE: if (req) state <= LOAD;
        LOAD: begin
          shreg <= cnt;
          idx   <= IW'(CNT_W - 1);
          state <= SHIFT;
        end
        SHIFT: begin
          shreg <= shreg << 1;
          idx   <= idx - 1'b1;
          if (idx == '0) begin
            state <= GAP;
            idx   <= IW'(GAP_CYCLES - 1);
          end
        end
        default: begin
          idx <= idx - 1'b1;
          if (idx == '0) state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tt_snapshot_shift_ctrl.sv
// tb_tt_snapshot_shift_ctrl: scoreboard bench; a countdown model predicts frames, a monitor checks them
module tb_tt_snapshot_shift_ctrl;
  localparam int CNT_W = 4, DIV_W = 3, GAP = 2;
  localparam int MODC = 1 << CNT_W, MODP = 1 << DIV_W;
  logic clk = 0, rst_n = 0, en = 0, start = 0, auto_mode = 0, clr_ovr = 0;
  logic [DIV_W-1:0] div = '0;
  logic sout, frame, busy, done, overrun;
  logic [CNT_W-1:0] cnt;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  tt_snapshot_shift_ctrl #(.CNT_W(CNT_W), .DIV_W(DIV_W), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div(div), .start(start), .auto_mode(auto_mode),
    .clr_ovr(clr_ovr), .sout(sout), .frame(frame), .busy(busy), .done(done),
    .overrun(overrun), .cnt(cnt)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  // reference: tick counter plus a "busy cycles left" countdown per accepted frame
  int m_pre, m_cnt, m_left;
  bit m_ovr, m_t, m_r;
  int exp_q[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pre = 0; m_cnt = 0; m_left = 0; m_ovr = 0;
      exp_q.delete();
    end else begin
      m_t = en && (m_pre == int'(div));
      m_r = start || (auto_mode && m_t);
      m_ovr = (m_r && m_left != 0) ? 1'b1 : clr_ovr ? 1'b0 : m_ovr;
      if (m_left != 0) m_left--;
      else if (m_r) begin
        exp_q.push_back((m_cnt + int'(m_t)) % MODC);
        m_left = CNT_W + GAP + 1;
      end
      m_pre = m_t ? 0 : en ? (m_pre + 1) % MODP : m_pre;
      m_cnt = (m_cnt + int'(m_t)) % MODC;
    end
  end
  int word, nbits, last_word, e;
  int got_q[$];
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word = 0; nbits = 0;
    end else begin
      chk("busy", busy, m_left != 0);
      chk("frame", frame, m_left > GAP && m_left <= GAP + CNT_W);
      chk("done", done, m_left == 1);
      chk("overrun", overrun, m_ovr);
      chk("cnt", cnt, m_cnt);
      if (frame) begin
        word = word * 2 + int'(sout);
        nbits++;
      end else chk("sout_idle", sout, 0);
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("frame_value", word, e);
          chk("frame_bits", nbits, CNT_W);
          last_word = word;
          got_q.push_back(word);
        end
        word = 0; nbits = 0;
      end
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_sout", sout, 0); chk("rst_frame", frame, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_ovr", overrun, 0); chk("rst_cnt", cnt, 0);
    rst_n = 1;
    en = 1; div = 2;
    repeat (3) @(negedge clk);
    chk("div2_first_tick", cnt, 1);
    repeat (45) @(negedge clk);
    chk("div2_wrap", cnt, 0);
    div = 0;
    repeat (10) @(negedge clk);
    chk("div0_count", cnt, 10);
    en = 0; start = 1;
    @(negedge clk); start = 0;
    repeat (10) @(negedge clk);
    chk("frame_A", last_word, 10);
    en = 1; div = 0;
    for (int i = 0; i < 40 && cnt != 5; i++) @(negedge clk);
    chk("reach_cnt5", cnt, 5);
    start = 1;
    @(negedge clk); start = 0;
    repeat (10) @(negedge clk);
    chk("snapshot_race", last_word, 6);
    start = 1;
    repeat (30) @(negedge clk);
    start = 0;
    chk("overrun_set", overrun, 1);
    repeat (10) @(negedge clk);
    clr_ovr = 1;
    @(negedge clk); clr_ovr = 0;
    chk("overrun_clr", overrun, 0);
    got_q.delete();
    auto_mode = 1; div = 7; en = 1;
    repeat (90) @(negedge clk);
    auto_mode = 0;
    repeat (10) @(negedge clk);
    chk("auto_no_ovr", overrun, 0);
    chk("auto_frames", got_q.size() >= 8, 1);
    for (int i = 1; i < got_q.size(); i++)
      chk("auto_consec", got_q[i], (got_q[i-1] + 1) % MODC);
    start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    chk("pre_rst_frame", frame, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_sout", sout, 0); chk("mid_rst_frame", frame, 0); chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0); chk("mid_rst_cnt", cnt, 0);
    @(negedge clk); rst_n = 1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", busy, 0);
    for (int i = 0; i < 2000; i++) begin
      en = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 15) == 0) div = DIV_W'($urandom);
      start = $urandom_range(0, 9) < 3;
      if ($urandom_range(0, 31) == 0) auto_mode = ~auto_mode;
      clr_ovr = $urandom_range(0, 9) == 0;
      @(negedge clk);
    end
    start = 0; auto_mode = 0; clr_ovr = 0;
    repeat (20) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
